// File: rtl/nibble_serial_pkg.sv
// Shared constants for the nibble-serial adder: slice width and FSM state encodings.
package nibble_serial_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/adder4bit.sv
// 4-bit ripple-carry adder slice, shared across cycles by nibble_serial_adder.
module adder4bit
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum,
  output logic                Cout
);

  always_comb begin : ripple
    logic [NIBBLE_W:0] c;
    c    = '0;
    c[0] = Cin;
    Sum  = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built by stepping one 4-bit adder over NIBBLES cycles, LS nibble first.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         cin,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  logic [0:0]          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [W-1:0]        sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  // Slice base is idx*4; the 2'b00 suffix is the multiply by NIBBLE_W.
  assign nib_a = opa_q[{idx_q, 2'b00} +: NIBBLE_W];
  assign nib_b = opb_q[{idx_q, 2'b00} +: NIBBLE_W];

  adder4bit u_adder (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[{idx_q, 2'b00} +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        if (idx_q == LastIdx) begin
          // Publish the whole word at once so sum never exposes partial slices.
          sum_d   = acc_d;
          cout_d  = nib_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
